// File: rtl/audio_mix_pkg.sv
// Shared types and helpers for the tone mixer: FSM states, pan routing bits,
// accumulator sizing and the clamp to codec sample width.
package audio_mix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SAT,
    ST_WRITE
  } mix_state_e;

  // Bit positions inside each voice's 2-bit pan field.
  localparam int PAN_LEFT  = 0;
  localparam int PAN_RIGHT = 1;

  // Widest accumulator the saturation helper handles.
  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic  clamped;
    wide_t value;
  } sat_result_t;

  // Sample width plus room for every voice's full-scale contribution and a sign
  // guard bit, so the running sum can never wrap.
  function automatic int acc_width(input int sample_w, input int num_voices);
    return sample_w + $clog2(num_voices + 1) + 1;
  endfunction

  // Clamp a sign-extended accumulator into the signed range of sample_w bits.
  function automatic sat_result_t saturate(input wide_t acc, input int sample_w);
    wide_t       hi;
    wide_t       lo;
    sat_result_t res;
    hi = (wide_t'(1) <<< (sample_w - 1)) - wide_t'(1);
    lo = ~hi;
    res.clamped = 1'b0;
    res.value   = acc;
    if (acc > hi) begin
      res.value   = hi;
      res.clamped = 1'b1;
    end else if (acc < lo) begin
      res.value   = lo;
      res.clamped = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One free-running square-wave voice. The gate is re-sampled only at polarity
// edges so switching a voice on or off never cuts a half-cycle short.
module tone_voice #(
  parameter int PERIOD_W = 19,
  parameter int AMP_W    = 24,
  parameter int SAMPLE_W = 32
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  input  logic [PERIOD_W-1:0]        half_period,
  input  logic [AMP_W-1:0]           amp,
  input  logic                       enable,
  output logic signed [SAMPLE_W-1:0] sample
);

  logic [PERIOD_W-1:0]        cnt;
  logic                       polarity;
  logic                       active;
  logic signed [SAMPLE_W-1:0] amp_ext;

  // Amplitude is unsigned, so widen with zeros before giving it a sign.
  assign amp_ext = SAMPLE_W'(amp);

  // Half-period counter; >= lets a shortened period take effect at once.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      cnt      <= '0;
      polarity <= 1'b0;
      active   <= 1'b0;
    end else if (half_period == '0) begin
      cnt <= '0;
    end else if (cnt >= half_period) begin
      cnt      <= '0;
      polarity <= ~polarity;
      active   <= enable;
    end else begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end

  // Signed voice output: silent when stopped or gated off.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    sample = '0;
    if ((half_period != '0) && active) begin
      sample = polarity ? amp_ext : -amp_ext;
    end
  end

endmodule

// File: rtl/audio_tone_mixer.sv
// N-voice square-wave generator and saturating stereo mixer between the audio
// controller FIFOs and the codec. One voice is summed per cycle, then the sum
// is clamped to sample width and pushed out.
module audio_tone_mixer
  import audio_mix_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 32,
  parameter int PERIOD_W   = 19,
  parameter int AMP_W      = 24
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic [NUM_VOICES*PERIOD_W-1:0] voice_half_period,
  input  logic [NUM_VOICES*AMP_W-1:0]  voice_amp,
  input  logic [NUM_VOICES-1:0]        voice_enable,
  input  logic [NUM_VOICES*2-1:0]      voice_pan,
  input  logic                         mic_enable,
  input  logic                         clip_clear,
  input  logic                         audio_in_available,
  input  logic                         audio_out_allowed,
  input  logic signed [SAMPLE_W-1:0]   left_in,
  input  logic signed [SAMPLE_W-1:0]   right_in,
  output logic                         read_audio_in,
  output logic                         write_audio_out,
  output logic signed [SAMPLE_W-1:0]   left_out,
  output logic signed [SAMPLE_W-1:0]   right_out,
  output logic                         clip
);

  localparam int ACC_W = acc_width(SAMPLE_W, NUM_VOICES);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  logic signed [SAMPLE_W-1:0] voice_sample [NUM_VOICES];
  logic [1:0]                 voice_route  [NUM_VOICES];

  mix_state_e              state;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc_l;
  logic signed [ACC_W-1:0] acc_r;

  logic signed [ACC_W-1:0] cur_ext;
  logic [1:0]              cur_route;
  sat_result_t             sat_l;
  sat_result_t             sat_r;
  logic                    sat_event;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    tone_voice #(
      .PERIOD_W (PERIOD_W),
      .AMP_W    (AMP_W),
      .SAMPLE_W (SAMPLE_W)
    ) u_voice (
      .CLOCK_50    (CLOCK_50),
      .resetn      (resetn),
      .half_period (voice_half_period[v*PERIOD_W +: PERIOD_W]),
      .amp         (voice_amp[v*AMP_W +: AMP_W]),
      .enable      (voice_enable[v]),
      .sample      (voice_sample[v])
    );
    assign voice_route[v] = voice_pan[2*v +: 2];
  end

  // Pop the input FIFO only when a full round trip is guaranteed room to finish.
  assign read_audio_in = resetn && (state == ST_IDLE) &&
                         audio_in_available && audio_out_allowed;

  // Select the voice being summed this cycle and clamp both accumulators.
  always_comb begin
    cur_ext   = ACC_W'(voice_sample[idx]);
    cur_route = voice_route[idx];
    sat_l     = saturate(wide_t'(acc_l), SAMPLE_W);
    sat_r     = saturate(wide_t'(acc_r), SAMPLE_W);
    sat_event = (state == ST_SAT) && (sat_l.clamped || sat_r.clamped);
  end

  // Mix sequencer: latch mic sample, sum voices, clamp, push one stereo sample.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      idx             <= '0;
      acc_l           <= '0;
      acc_r           <= '0;
      left_out        <= '0;
      right_out       <= '0;
      write_audio_out <= 1'b0;
      clip            <= 1'b0;
    end else begin
      write_audio_out <= 1'b0;
      // A new clip in the same cycle as a clear keeps the flag set.
      clip <= (clip & ~clip_clear) | sat_event;
      case (state)
        ST_IDLE: begin
          if (read_audio_in) begin
            acc_l <= mic_enable ? ACC_W'(left_in)  : '0;
            acc_r <= mic_enable ? ACC_W'(right_in) : '0;
            idx   <= '0;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (cur_route[PAN_LEFT])  acc_l <= acc_l + cur_ext;
          if (cur_route[PAN_RIGHT]) acc_r <= acc_r + cur_ext;
          if (idx == LAST_IDX) begin
            state <= ST_SAT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_SAT: begin
          left_out        <= sat_l.value[SAMPLE_W-1:0];
          right_out       <= sat_r.value[SAMPLE_W-1:0];
          write_audio_out <= 1'b1;
          state           <= ST_WRITE;
        end
        ST_WRITE: begin
          // Output FIFO space was checked at read time; nothing else writes it.
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_tone_mixer.sv
// Directed bench for audio_tone_mixer: tone timing, mix path, saturation and
// clip flag, gated voices, flow control, and reset in the middle of a sample.
module tb_audio_tone_mixer;

  localparam int NV = 4;
  localparam int SW = 32;
  localparam int PW = 19;
  localparam int AW = 24;

  logic                   CLOCK_50 = 1'b0;
  logic                   resetn;
  logic [NV*PW-1:0]       voice_half_period;
  logic [NV*AW-1:0]       voice_amp;
  logic [NV-1:0]          voice_enable;
  logic [NV*2-1:0]        voice_pan;
  logic                   mic_enable;
  logic                   clip_clear;
  logic                   audio_in_available;
  logic                   audio_out_allowed;
  logic signed [SW-1:0]   left_in;
  logic signed [SW-1:0]   right_in;
  logic                   read_audio_in;
  logic                   write_audio_out;
  logic signed [SW-1:0]   left_out;
  logic signed [SW-1:0]   right_out;
  logic                   clip;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  audio_tone_mixer #(
    .NUM_VOICES (NV),
    .SAMPLE_W   (SW),
    .PERIOD_W   (PW),
    .AMP_W      (AW)
  ) dut (
    .CLOCK_50           (CLOCK_50),
    .resetn             (resetn),
    .voice_half_period  (voice_half_period),
    .voice_amp          (voice_amp),
    .voice_enable       (voice_enable),
    .voice_pan          (voice_pan),
    .mic_enable         (mic_enable),
    .clip_clear         (clip_clear),
    .audio_in_available (audio_in_available),
    .audio_out_allowed  (audio_out_allowed),
    .left_in            (left_in),
    .right_in           (right_in),
    .read_audio_in      (read_audio_in),
    .write_audio_out    (write_audio_out),
    .left_out           (left_out),
    .right_out          (right_out),
    .clip               (clip)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("comparison %s did not hold", tag);
    end
  endtask

  task automatic set_voice(input int v, input int hp, input int amp,
                           input logic en, input logic [1:0] pan);
    voice_half_period[v*PW +: PW] = PW'(hp);
    voice_amp[v*AW +: AW]         = AW'(amp);
    voice_enable[v]               = en;
    voice_pan[2*v +: 2]           = pan;
  endtask

  task automatic set_hp(input int v, input int hp);
    voice_half_period[v*PW +: PW] = PW'(hp);
  endtask

  // One sample transaction: returns read seen in the request cycle, cycles
  // from read to write (-1 if none within the window) and number of writes.
  task automatic run_sample(input logic signed [SW-1:0] l, input logic signed [SW-1:0] r,
                            output int rd, output int lat, output int nw);
    @(negedge CLOCK_50);
    left_in = l;
    right_in = r;
    audio_in_available = 1'b1;
    audio_out_allowed  = 1'b1;
    #1;
    rd  = int'(read_audio_in);
    lat = -1;
    nw  = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLOCK_50);
      if (k == 1) audio_in_available = 1'b0;
      if (write_audio_out) begin
        nw++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    int rd, lat, nw, found, n;
    logic prev;

    resetn = 1'b0;
    voice_half_period = '0;
    voice_amp = '0;
    voice_enable = '0;
    voice_pan = '0;
    mic_enable = 1'b1;
    clip_clear = 1'b0;
    audio_in_available = 1'b0;
    audio_out_allowed = 1'b0;
    left_in = '0;
    right_in = '0;
    set_voice(0, 9, 1000, 1'b1, 2'b11);

    // Reset state
    #5;
    check("rst_read", read_audio_in, 0);
    check("rst_write", write_audio_out, 0);
    check("rst_clip", clip, 0);
    check("rst_left", left_out, 0);
    check("rst_right", right_out, 0);
    check("rst_polarity", dut.g_voice[0].u_voice.polarity, 0);
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;

    // Single-voice tone: toggles every half_period+1 = 10 cycles
    found = 0;
    prev = dut.g_voice[0].u_voice.polarity;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLOCK_50);
      if (dut.g_voice[0].u_voice.polarity != prev) begin
        found = 1;
        break;
      end
    end
    check("tone_first_toggle", found, 1);
    check("tone_active", dut.g_voice[0].u_voice.active, 1);
    for (int rep = 0; rep < 2; rep++) begin
      n = 0;
      prev = dut.g_voice[0].u_voice.polarity;
      for (int k = 1; k <= 30; k++) begin
        @(negedge CLOCK_50);
        if (dut.g_voice[0].u_voice.polarity != prev) begin
          n = k;
          break;
        end
      end
      check("tone_half_period", n, 10);
    end

    // Freeze voice0 in the positive half, then route left only
    for (int k = 0; k < 30; k++) begin
      if (dut.g_voice[0].u_voice.polarity == 1'b1) break;
      @(negedge CLOCK_50);
    end
    set_hp(0, 1000);
    voice_pan[1:0] = 2'b01;
    check("mix_v0_positive", dut.g_voice[0].u_voice.polarity, 1);

    // Mix path: 500 + 1000 left, -200 right, write six cycles after read
    run_sample(500, -200, rd, lat, nw);
    check("mix_read", rd, 1);
    check("mix_latency", lat, 6);
    check("mix_writes", nw, 1);
    check("mix_left", left_out, 1500);
    check("mix_right", right_out, -200);

    // Saturation: bring voices 1..3 to +1000 in lockstep, all panned left
    @(negedge CLOCK_50);
    for (int v = 1; v < NV; v++) set_voice(v, 9, 1000, 1'b1, 2'b01);
    for (int k = 0; k < 20; k++) begin
      @(negedge CLOCK_50);
      if (dut.g_voice[1].u_voice.polarity == 1'b1) break;
    end
    for (int v = 1; v < NV; v++) set_hp(v, 1000);
    check("sat_v3_active", dut.g_voice[3].u_voice.active, 1);
    check("sat_v3_positive", dut.g_voice[3].u_voice.polarity, 1);
    run_sample(2147483548, 0, rd, lat, nw);
    check("sat_latency", lat, 6);
    check("sat_left", left_out, 2147483647);
    check("sat_right", right_out, 0);
    check("sat_clip_set", clip, 1);
    @(negedge CLOCK_50);
    clip_clear = 1'b1;
    @(negedge CLOCK_50);
    clip_clear = 1'b0;
    check("sat_clip_cleared", clip, 0);

    // Gate: voice0 disabled mid half-period keeps sounding; zero period mutes 1..3
    @(negedge CLOCK_50);
    for (int v = 1; v < NV; v++) set_hp(v, 0);
    voice_enable[0] = 1'b0;
    run_sample(0, 0, rd, lat, nw);
    check("gate_hold_left", left_out, 1000);
    check("gate_hold_right", right_out, 0);
    set_hp(0, 1);
    @(negedge CLOCK_50);
    set_hp(0, 1000);
    check("gate_inactive", dut.g_voice[0].u_voice.active, 0);
    run_sample(0, 0, rd, lat, nw);
    check("gate_off_left", left_out, 0);
    check("gate_no_clip", clip, 0);

    // Flow control: output full blocks the read
    audio_in_available = 1'b1;
    audio_out_allowed  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK_50);
      check("flow_no_read", read_audio_in, 0);
    end
    check("flow_no_write", write_audio_out, 0);
    audio_in_available = 1'b0;

    // Mic disabled: FIFO still popped, outputs carry the voice only
    mic_enable = 1'b0;
    voice_enable[0] = 1'b1;
    voice_pan[1:0] = 2'b11;
    set_hp(0, 1);
    @(negedge CLOCK_50);
    set_hp(0, 1000);
    run_sample(12345, -999, rd, lat, nw);
    check("mic_off_read", rd, 1);
    check("mic_off_left", left_out, 1000);
    check("mic_off_right", right_out, 1000);
    mic_enable = 1'b1;

    // Reset in the middle of accumulation
    @(negedge CLOCK_50);
    left_in = 111;
    right_in = 222;
    audio_in_available = 1'b1;
    audio_out_allowed  = 1'b1;
    @(negedge CLOCK_50);
    #3;
    resetn = 1'b0;
    #1;
    check("mid_rst_read", read_audio_in, 0);
    check("mid_rst_write", write_audio_out, 0);
    check("mid_rst_left", left_out, 0);
    check("mid_rst_right", right_out, 0);
    check("mid_rst_clip", clip, 0);
    check("mid_rst_v0_active", dut.g_voice[0].u_voice.active, 0);
    @(negedge CLOCK_50);
    audio_in_available = 1'b0;
    resetn = 1'b1;
    nw = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLOCK_50);
      if (write_audio_out) nw++;
    end
    check("post_rst_no_write", nw, 0);
    run_sample(7, -7, rd, lat, nw);
    check("post_rst_latency", lat, 6);
    check("post_rst_left", left_out, 7);
    check("post_rst_right", right_out, -7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/audio_tone_mixer.md
# audio_tone_mixer

Parametrised N-voice square-wave tone generator and saturating mixer that sits between the `Audio_Controller` FIFOs and the codec path. Each sample period it consumes one stereo microphone sample, adds the panned contribution of every active voice, saturates to the codec sample width and writes one stereo sample back. Each voice has its own period, amplitude, pan and gate. A gate change takes effect only at that voice's next polarity edge, so enabling or disabling a voice does not click.

## Interface
- `NUM_VOICES`, 4: number of independent tone voices (1..16)
- `SAMPLE_W`, 32: signed audio sample width, matching the controller channel width
- `PERIOD_W`, 19: half-period counter width, in `CLOCK_50` cycles
- `AMP_W`, 24: unsigned voice amplitude width; must satisfy `AMP_W < SAMPLE_W`

Ports:
- `CLOCK_50`  in  1  single system clock
- `resetn`  in  1  reset; **asynchronous, active-low**
- `voice_half_period`  in  NUM_VOICES*PERIOD_W  per-voice half period; 0 = voice silent
- `voice_amp`  in  NUM_VOICES*AMP_W  per-voice unsigned amplitude
- `voice_enable`  in  NUM_VOICES  per-voice gate request
- `voice_pan`  in  NUM_VOICES*2  per voice: bit0 = route to left, bit1 = route to right
- `mic_enable`  in  1  1 = mix microphone input; 0 = treat input as 0, FIFO still drained
- `clip_clear`  in  1  synchronous clear of `clip`
- `audio_in_available`  in  1  controller input FIFO non-empty
- `audio_out_allowed`  in  1  controller output FIFO has space
- `left_in`, `right_in`  in  SAMPLE_W each  signed microphone samples
- `read_audio_in`  out  1  one-cycle input FIFO pop
- `write_audio_out`  out  1  one-cycle output FIFO push
- `left_out`, `right_out`  out  SAMPLE_W each  signed mixed samples
- `clip`  out  1  sticky flag: saturation occurred

## Operation
- **Voice oscillator (always free-running, independent of the FSM)**
  - If `half_period == 0`: `cnt` is held at 0, polarity does not change, and the voice contributes 0.
  - Otherwise, when `cnt >= half_period`: `cnt <= 0`, polarity toggles, and `active <= voice_enable`. Otherwise `cnt` increments.
  - Using `>=` lets a lowered period take effect immediately.
  - Tone frequency = 50 MHz / (2·(half_period+1)).
- **Voice sample:** `active ? (polarity ? +amp : −amp) : 0`, sign-extended.
- **Mix FSM states:**
  - **IDLE:** when `audio_in_available && audio_out_allowed`, assert `read_audio_in` combinationally in that cycle. On the same edge, latch `left_in`/`right_in` (or 0 if `!mic_enable`) into the accumulators and go to ACCUM with index 0.
  - **ACCUM:** one voice per cycle, for `NUM_VOICES` cycles. Add the voice sample to the left accumulator if pan bit0 is set, and to the right if bit1 is set. Voice state is sampled in the cycle that voice is accumulated.
  - **SAT:** clamp each accumulator to [−2^(SAMPLE_W−1), 2^(SAMPLE_W−1)−1] and register the result into `left_out`/`right_out`. Set `clip` if either channel clamped.
  - **WRITE:** `write_audio_out = 1` for one cycle with outputs stable, then return to IDLE.
- **Accumulator width:** `SAMPLE_W + clog2(NUM_VOICES+1) + 1`, signed. The accumulator cannot overflow internally.
- **`audio_out_allowed` is not rechecked in WRITE.** This block is the sole writer, so FIFO space cannot shrink between IDLE and WRITE.
- **`clip`:** sticky. When `clip_clear` and a new clip event occur in the same cycle, the set wins.

## Timing
- Read in cycle T, write in cycle T+NUM_VOICES+2, next read no earlier than T+NUM_VOICES+3.
  - Default parameters: 7-cycle service time, far below the ~1042-cycle sample period at 48 kHz.
- `left_out`/`right_out` change only on the SAT→WRITE edge and hold until the next SAT.
- Values after `resetn` low (asynchronous):
  - FSM = IDLE
  - `read_audio_in`, `write_audio_out`, `clip` = 0
  - `left_out`, `right_out` = 0
  - all `cnt` = 0, polarity = 0 (negative), `active` = 0
- Reset asserted mid-sample abandons that sample; no write is issued. A sample already popped is lost, which is acceptable.
- `voice_*` inputs are quasi-static; no synchroniser is needed, since they originate in `CLOCK_50` logic.

## Structure
- **Package `audio_mix_pkg`:**
  - FSM state enum {IDLE, ACCUM, SAT, WRITE}
  - accumulator-width function
  - saturation function with sat-flag output
  - pan bit indices
- **Sub-module `tone_voice`:** one instance per voice via generate. It holds `cnt`, `polarity` and `active`, and outputs a signed voice sample. The mixer FSM, accumulators and saturation stay in `audio_tone_mixer`.

## Test plan
- **Single-voice tone:** N=4; voice0 half_period=9, amp=1000, enable=1, pan=2'b11, other voices off; no FIFO traffic → after the first toggle, voice0 polarity toggles every 10 cycles and `active` = 1.
- **Mix path:** FIFO always ready; `left_in=500`, `right_in=−200`, voice0 sampled at +1000 with pan=2'b01 → `read_audio_in` at T, `write_audio_out` at T+6 with `left_out=1500`, `right_out=−200`.
- **Saturation:** `left_in=2^31−100`; voices 0..3 at +1000, pan left → `left_out=2^31−1`, `clip=1`. Then `clip_clear` pulse with no clipping → `clip=0`.
- **Glitch-free gate:** drop `voice_enable[0]` mid half-period → contribution persists until that voice's next toggle, then becomes 0. `half_period=0` → contribution is 0 immediately.
- **Flow control:**
  - `audio_out_allowed=0` with `audio_in_available=1` → no read.
  - `mic_enable=0` → the read still occurs and the outputs contain voices only.
- **Reset mid-ACCUM:** assert `resetn=0` → all outputs 0 asynchronously. After release, no stray `write_audio_out`, and the next sample is processed normally.
